// File: rtl/skid_buffer_32bit.sv
// Two-entry skid buffer. A word is visible on out_data one cycle after it is written.
// All handshake outputs come from flops; in_ready drops only when both registers are occupied.
module skid_buffer_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    // Encoding matches the occupancy, so count is the state register itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             wr, rd;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign count     = state_q;

    assign wr = in_valid && in_ready;
    assign rd = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (wr) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (wr && rd) begin
                        main_d = in_data;
                    end else if (wr) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (rd) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (rd) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_skid_buffer_32bit.sv
// Bench for skid_buffer_32bit: queue-based reference model checked every negedge,
// plus directed scenarios with literal expectations.
module tb_skid_buffer_32bit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    skid_buffer_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a FIFO of at most two words plus the last word presented.
    logic [31:0] mq[$];
    logic [31:0] m_main;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_main = 32'h0;
        end else begin
            int sz;
            bit wr, rd;
            sz = mq.size();
            wr = in_valid && (sz < 2);
            rd = out_ready && (sz > 0);
            if (flush) begin
                mq.delete();
                m_main = 32'h0;
            end else begin
                if (rd) void'(mq.pop_front());
                if (wr) mq.push_back(in_data);
                if (mq.size() > 0) m_main = mq[0];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model, plus stall-stability of out_data.
    bit          prev_stall = 0;
    logic [31:0] prev_data  = 32'h0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            chk("model count",     {30'b0, count},    32'(mq.size()));
            chk("model out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
            chk("model in_ready",  {31'b0, in_ready},  {31'b0, mq.size() < 2});
            chk("model out_data",  out_data,           m_main);
            if (prev_stall) chk("stall stable", out_data, prev_data);
            prev_stall = (mq.size() != 0) && !out_ready && !flush;
            prev_data  = out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        #2;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset in_ready",  {31'b0, in_ready},  32'd1);
        chk("reset count",     {30'b0, count},     32'd0);
        chk("reset out_data",  out_data,           32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single word, one-cycle latency.
        in_valid = 1'b1; in_data = 32'h00000001; out_ready = 1'b1;
        step();
        idle();
        chk("s1 out_valid", {31'b0, out_valid}, 32'd1);
        chk("s1 out_data",  out_data,           32'h00000001);
        chk("s1 count",     {30'b0, count},     32'd1);
        step();
        chk("s1 drained", {31'b0, out_valid}, 32'd0);

        // Fill to FULL under stall, hold, then drain back-to-back.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hAAAA5555;
        step();
        in_data = 32'h12345678;
        step();
        idle();
        in_data = 32'hFFFFFFFF;
        chk("s2 count",    {30'b0, count},    32'd2);
        chk("s2 in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            step();
            chk("s2 held", out_data, 32'hAAAA5555);
        end
        idle();
        out_ready = 1'b1;
        chk("s2 first", out_data, 32'hAAAA5555);
        step();
        chk("s2 second", out_data, 32'h12345678);
        chk("s2 second vld", {31'b0, out_valid}, 32'd1);
        step();
        chk("s2 empty", {31'b0, out_valid}, 32'd0);

        // Full-rate stream.
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            step();
            chk("s3 data", out_data, 32'(i));
            if (count > 2'd1) chk("s3 count<=1", {30'b0, count}, 32'd1);
        end
        idle();
        step();
        chk("s3 drained", {31'b0, out_valid}, 32'd0);

        // Flush beats simultaneous write and read.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h00000011;
        step();
        in_data = 32'h00000022;
        step();
        chk("s4 full", {30'b0, count}, 32'd2);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h00000033; out_ready = 1'b1;
        step();
        idle();
        chk("s4 count",     {30'b0, count},     32'd0);
        chk("s4 out_valid", {31'b0, out_valid}, 32'd0);
        chk("s4 out_data",  out_data,           32'h0);
        step();
        chk("s4 dropped", {31'b0, out_valid}, 32'd0);

        // Async reset pulse while FULL.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h00000044;
        step();
        in_data = 32'h00000055;
        step();
        idle();
        chk("s5 full", {30'b0, count}, 32'd2);
        rst_n = 1'b0;
        #2;
        chk("s5 out_valid", {31'b0, out_valid}, 32'd0);
        chk("s5 in_ready",  {31'b0, in_ready},  32'd1);
        chk("s5 out_data",  out_data,           32'h0);
        #3;
        rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        step();
        idle();
        chk("s5 word",  out_data,       32'hDEADBEEF);
        chk("s5 count", {30'b0, count}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("s5 alone", {31'b0, out_valid}, 32'd0);

        // Random handshake traffic.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        idle();
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("final drained", {31'b0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
